// File: rtl/arm_mem_pkg.sv
// Shared definitions for the memory bus arbiter: access-size encodings,
// FSM state constants, grant source encoding and the alignment check.
package arm_mem_pkg;

    // Access size encodings carried on ls_size.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Arbiter FSM state type and constants.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ACCESS = 2'd1;
    localparam state_t ST_RESP   = 2'd2;

    // Grant source encoding.
    localparam logic SRC_IF = 1'b0;
    localparam logic SRC_LS = 1'b1;

    // True when the access cannot be issued as a single aligned RAM cycle.
    // Size 11 has no meaning and is rejected the same way.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = addr_lo[0];
            SZ_WORD: mis = (addr_lo != 2'b00);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between the core and the 32-bit RAM port.
// Produces byte enables, replicated write data, the extracted and
// extended read value, and the misaligned flag for one access.
module mem_lane_align
    import arm_mem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        signed_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misaligned_o
);

    logic [31:0] shifted_s;

    // Move the addressed lane down to bit 0, then pick enables, write
    // replication and read extension by access size.
    always_comb begin
        shifted_s    = rdata_i >> {addr_lo_i, 3'b000};
        misaligned_o = is_misaligned(size_i, addr_lo_i);
        be_o         = 4'b0000;
        wdata_o      = wdata_i;
        rdata_o      = 32'h0000_0000;
        case (size_i)
            SZ_BYTE: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{signed_i & shifted_s[7]}}, shifted_s[7:0]};
            end
            SZ_HALF: begin
                be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {{16{signed_i & shifted_s[15]}}, shifted_s[15:0]};
            end
            SZ_WORD: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
                rdata_o = rdata_i;
            end
            default: begin
                be_o    = 4'b0000;
                wdata_o = wdata_i;
                rdata_o = 32'h0000_0000;
            end
        endcase
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbiter and sequencer for the single external RAM port shared by
// instruction fetch (IF) and load/store (LS). IDLE -> ACCESS -> RESP.
// All RAM strobes and requester responses are registered.
// Optional build macro MEM_TIMEOUT_EN adds a ram_ready wait limit of
// TIMEOUT_CYCLES; without it ACCESS waits indefinitely.
module mem_bus_arbiter
    import arm_mem_pkg::*;
#(
    parameter bit FAIR_ARB = 1'b1
`ifdef MEM_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [1:0]  ls_size,
    input  logic        ls_signed,
    input  logic [31:0] ls_wdata,
    output logic        ls_ack,
    output logic [31:0] ls_rdata,
    output logic        ls_err,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        cs,
    output logic        we,
    output logic        oe,
    input  logic        ram_ready,
    output logic        busy
);

    // FSM and latched access attributes.
    state_t      state_q,      state_d;
    logic        last_grant_q, last_grant_d;
    logic        src_q,        src_d;
    logic [1:0]  size_q,       size_d;
    logic [1:0]  addr_lo_q,    addr_lo_d;
    logic        we_q,         we_d;
    logic        signed_q,     signed_d;

    // Registered outputs.
    logic        cs_q,        cs_d;
    logic        mem_we_q,    mem_we_d;
    logic        oe_q,        oe_d;
    logic [31:0] mem_addr_q,  mem_addr_d;
    logic [3:0]  mem_be_q,    mem_be_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        if_ack_q,    if_ack_d;
    logic        ls_ack_q,    ls_ack_d;
    logic [31:0] if_rdata_q,  if_rdata_d;
    logic [31:0] ls_rdata_q,  ls_rdata_d;
    logic        if_err_q,    if_err_d;
    logic        ls_err_q,    ls_err_d;
    logic        busy_q,      busy_d;

    // Response payload for the cycle that enters RESP.
    logic [31:0] resp_rdata_d;
    logic        resp_err_d;

    // Arbitration candidate.
    logic        grant_any_s;
    logic        grant_src_s;
    logic        prefer_if_s;
    logic [31:0] cand_addr_s;
    logic [1:0]  cand_size_s;
    logic        cand_we_s;
    logic        cand_signed_s;

    // Lane steering.
    logic [1:0]  align_size_s;
    logic [1:0]  align_addr_lo_s;
    logic        align_signed_s;
    logic [3:0]  lane_be_s;
    logic [31:0] lane_wdata_s;
    logic [31:0] lane_rdata_s;
    logic        lane_mis_s;

`ifdef MEM_TIMEOUT_EN
    logic [31:0] tmo_cnt_q, tmo_cnt_d;
`endif

    // Pick the winner among pending requests and gather its access fields.
    always_comb begin
        prefer_if_s = FAIR_ARB && (last_grant_q == SRC_LS);
        grant_any_s = if_req | ls_req;
        if (if_req && ls_req) begin
            grant_src_s = prefer_if_s ? SRC_IF : SRC_LS;
        end else if (ls_req) begin
            grant_src_s = SRC_LS;
        end else begin
            grant_src_s = SRC_IF;
        end
        if (grant_src_s == SRC_LS) begin
            cand_addr_s   = ls_addr;
            cand_size_s   = ls_size;
            cand_we_s     = ls_we;
            cand_signed_s = ls_signed;
        end else begin
            cand_addr_s   = if_addr;
            cand_size_s   = SZ_WORD;
            cand_we_s     = 1'b0;
            cand_signed_s = 1'b0;
        end
    end

    // In IDLE the lane logic sees the candidate; afterwards the latched access.
    always_comb begin
        if (state_q == ST_IDLE) begin
            align_size_s    = cand_size_s;
            align_addr_lo_s = cand_addr_s[1:0];
            align_signed_s  = cand_signed_s;
        end else begin
            align_size_s    = size_q;
            align_addr_lo_s = addr_lo_q;
            align_signed_s  = signed_q;
        end
    end

    mem_lane_align u_lane (
        .size_i       (align_size_s),
        .addr_lo_i    (align_addr_lo_s),
        .signed_i     (align_signed_s),
        .wdata_i      (ls_wdata),
        .rdata_i      (mem_rdata),
        .be_o         (lane_be_s),
        .wdata_o      (lane_wdata_s),
        .rdata_o      (lane_rdata_s),
        .misaligned_o (lane_mis_s)
    );

    // FSM next state, access latching and response payload.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        src_d        = src_q;
        size_d       = size_q;
        addr_lo_d    = addr_lo_q;
        we_d         = we_q;
        signed_d     = signed_q;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;
        resp_rdata_d = 32'h0000_0000;
        resp_err_d   = 1'b0;
`ifdef MEM_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (grant_any_s) begin
                    src_d        = grant_src_s;
                    last_grant_d = grant_src_s;
                    size_d       = cand_size_s;
                    addr_lo_d    = cand_addr_s[1:0];
                    we_d         = cand_we_s;
                    signed_d     = cand_signed_s;
                    if (lane_mis_s) begin
                        // Rejected without touching the RAM.
                        state_d    = ST_RESP;
                        resp_err_d = 1'b1;
                    end else begin
                        state_d     = ST_ACCESS;
                        mem_addr_d  = {cand_addr_s[31:2], 2'b00};
                        mem_be_d    = lane_be_s;
                        mem_wdata_d = lane_wdata_s;
`ifdef MEM_TIMEOUT_EN
                        tmo_cnt_d   = 32'd0;
`endif
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (ram_ready) begin
                    state_d      = ST_RESP;
                    resp_rdata_d = we_q ? 32'h0000_0000 : lane_rdata_s;
`ifdef MEM_TIMEOUT_EN
                end else if (tmo_cnt_q == (TIMEOUT_CYCLES - 32'd1)) begin
                    state_d    = ST_RESP;
                    resp_err_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 32'd1;
`else
                end else begin
                    state_d = ST_ACCESS;
`endif
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output values for the next cycle, derived from the next state so
    // that strobes and acks line up with the state they belong to.
    always_comb begin
        cs_d       = (state_d == ST_ACCESS);
        mem_we_d   = cs_d & we_d;
        oe_d       = cs_d & ~we_d;
        busy_d     = (state_d != ST_IDLE);
        if_ack_d   = (state_d == ST_RESP) && (src_d == SRC_IF);
        ls_ack_d   = (state_d == ST_RESP) && (src_d == SRC_LS);
        if (if_ack_d) begin
            if_rdata_d = resp_rdata_d;
            if_err_d   = resp_err_d;
        end else begin
            if_rdata_d = if_rdata_q;
            if_err_d   = if_err_q;
        end
        if (ls_ack_d) begin
            ls_rdata_d = resp_rdata_d;
            ls_err_d   = resp_err_d;
        end else begin
            ls_rdata_d = ls_rdata_q;
            ls_err_d   = ls_err_q;
        end
    end

    // State and output registers; reset drops strobes immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= SRC_IF;
            src_q        <= SRC_IF;
            size_q       <= SZ_BYTE;
            addr_lo_q    <= 2'b00;
            we_q         <= 1'b0;
            signed_q     <= 1'b0;
            cs_q         <= 1'b0;
            mem_we_q     <= 1'b0;
            oe_q         <= 1'b0;
            mem_addr_q   <= 32'h0000_0000;
            mem_be_q     <= 4'b0000;
            mem_wdata_q  <= 32'h0000_0000;
            if_ack_q     <= 1'b0;
            ls_ack_q     <= 1'b0;
            if_rdata_q   <= 32'h0000_0000;
            ls_rdata_q   <= 32'h0000_0000;
            if_err_q     <= 1'b0;
            ls_err_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            src_q        <= src_d;
            size_q       <= size_d;
            addr_lo_q    <= addr_lo_d;
            we_q         <= we_d;
            signed_q     <= signed_d;
            cs_q         <= cs_d;
            mem_we_q     <= mem_we_d;
            oe_q         <= oe_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
            if_ack_q     <= if_ack_d;
            ls_ack_q     <= ls_ack_d;
            if_rdata_q   <= if_rdata_d;
            ls_rdata_q   <= ls_rdata_d;
            if_err_q     <= if_err_d;
            ls_err_q     <= ls_err_d;
            busy_q       <= busy_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    // ACCESS cycle counter for the ram_ready wait limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q <= 32'd0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`endif

    assign cs        = cs_q;
    assign we        = mem_we_q;
    assign oe        = oe_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign if_ack    = if_ack_q;
    assign ls_ack    = ls_ack_q;
    assign if_rdata  = if_rdata_q;
    assign ls_rdata  = ls_rdata_q;
    assign if_err    = if_err_q;
    assign ls_err    = ls_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a table of single accesses plus
// hand sequences for contention, reset mid-access and (with
// MEM_TIMEOUT_EN) the ram_ready wait limit.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, ls_req, nf_if_req, nf_ls_req;
    logic [31:0] if_addr, ls_addr, ls_wdata, mem_rdata;
    logic        ls_we, ls_signed, ram_ready;
    logic [1:0]  ls_size;

    logic        if_ack, if_err, ls_ack, ls_err, cs, we, oe, busy;
    logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    logic        nf_if_ack, nf_if_err, nf_ls_ack, nf_ls_err, nf_cs, nf_we, nf_oe, nf_busy;
    logic [31:0] nf_if_rdata, nf_ls_rdata, nf_mem_addr, nf_mem_wdata;
    logic [3:0]  nf_mem_be;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .FAIR_ARB(1'b1)
`ifdef MEM_TIMEOUT_EN
        , .TIMEOUT_CYCLES(8)
`endif
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_size(ls_size), .ls_signed(ls_signed),
        .ls_wdata(ls_wdata), .ls_ack(ls_ack), .ls_rdata(ls_rdata), .ls_err(ls_err),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .cs(cs), .we(we), .oe(oe), .ram_ready(ram_ready), .busy(busy)
    );

    mem_bus_arbiter #(
        .FAIR_ARB(1'b0)
`ifdef MEM_TIMEOUT_EN
        , .TIMEOUT_CYCLES(8)
`endif
    ) dut_nf (
        .clk(clk), .rst(rst),
        .if_req(nf_if_req), .if_addr(if_addr), .if_ack(nf_if_ack), .if_rdata(nf_if_rdata), .if_err(nf_if_err),
        .ls_req(nf_ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_size(ls_size), .ls_signed(ls_signed),
        .ls_wdata(ls_wdata), .ls_ack(nf_ls_ack), .ls_rdata(nf_ls_rdata), .ls_err(nf_ls_err),
        .mem_addr(nf_mem_addr), .mem_be(nf_mem_be), .mem_wdata(nf_mem_wdata), .mem_rdata(mem_rdata),
        .cs(nf_cs), .we(nf_we), .oe(nf_oe), .ram_ready(ram_ready), .busy(nf_busy)
    );

    typedef struct {
        bit          is_ls;
        bit          st;
        logic [31:0] addr;
        logic [1:0]  size;
        bit          sgn;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
        logic [3:0]  e_be;
        logic [31:0] e_maddr;
        logic [31:0] e_wdata;
        logic [31:0] e_rdata;
        bit          e_err;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drop_reqs();
        if_req = 1'b0; ls_req = 1'b0; nf_if_req = 1'b0; nf_ls_req = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drop_reqs();
        ram_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Apply one table entry; called at a falling edge.
    task automatic run_vec(input int idx, input vec_t v);
        int          cs_n;
        int          lat;
        bit          got;
        logic [31:0] rd;
        logic        er;
        logic        other;
        cs_n = 0; lat = 0; got = 1'b0; rd = 32'h0; er = 1'b0; other = 1'b0;
        mem_rdata = v.rdata;
        ram_ready = (v.delay == 0);
        if (v.is_ls) begin
            ls_req = 1'b1; ls_we = v.st; ls_addr = v.addr; ls_size = v.size;
            ls_signed = v.sgn; ls_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        for (int k = 1; k <= 30 && !got; k++) begin
            @(negedge clk);
            if (cs) begin
                cs_n++;
                chk($sformatf("v%0d_mem_be", idx), {28'h0, mem_be}, {28'h0, v.e_be});
                chk($sformatf("v%0d_mem_addr", idx), mem_addr, v.e_maddr);
                chk($sformatf("v%0d_we_oe", idx), {30'h0, we, oe}, {30'h0, v.st, ~v.st});
                if (v.st) chk($sformatf("v%0d_mem_wdata", idx), mem_wdata, v.e_wdata);
                if (cs_n == v.delay + 1) ram_ready = 1'b1;
            end
            if (if_ack || ls_ack) begin
                got   = 1'b1;
                lat   = k;
                rd    = v.is_ls ? ls_rdata : if_rdata;
                er    = v.is_ls ? ls_err : if_err;
                other = v.is_ls ? if_ack : ls_ack;
            end
        end
        chk($sformatf("v%0d_acked", idx), {31'h0, got}, 32'h1);
        chk($sformatf("v%0d_other_ack", idx), {31'h0, other}, 32'h0);
        chk($sformatf("v%0d_err", idx), {31'h0, er}, {31'h0, v.e_err});
        if (v.e_err) begin
            chk($sformatf("v%0d_latency", idx), lat, 32'd1);
            chk($sformatf("v%0d_cs_cycles", idx), cs_n, 32'd0);
        end else begin
            chk($sformatf("v%0d_latency", idx), lat, v.delay + 2);
            chk($sformatf("v%0d_cs_cycles", idx), cs_n, v.delay + 1);
            if (!v.st) chk($sformatf("v%0d_rdata", idx), rd, v.e_rdata);
        end
        drop_reqs();
        ram_ready = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d_idle_after", idx), {30'h0, busy, ls_ack | if_ack}, 32'h0);
    endtask

    // Both requesters kept pending; each winner drops req after its ack and
    // re-raises it, for four grants; the fifth grant drains the loser.
    task automatic contend(input bit nf, input logic [4:0] exp_ls);
        bit got;
        bit win_ls;
        if_addr = 32'h0000_0010;
        ls_we = 1'b0; ls_addr = 32'h0000_0020; ls_size = 2'b10; ls_signed = 1'b0;
        mem_rdata = 32'h1111_2222;
        ram_ready = 1'b1;
        if (nf) begin nf_if_req = 1'b1; nf_ls_req = 1'b1; end
        else    begin if_req = 1'b1;    ls_req = 1'b1;    end
        for (int g = 0; g < 5; g++) begin
            got = 1'b0; win_ls = 1'b0;
            for (int k = 0; k < 20 && !got; k++) begin
                @(negedge clk);
                if (nf ? (nf_if_ack | nf_ls_ack) : (if_ack | ls_ack)) begin
                    got = 1'b1;
                    win_ls = nf ? nf_ls_ack : ls_ack;
                end
            end
            chk($sformatf("%s_grant%0d_seen", nf ? "nf" : "fair", g), {31'h0, got}, 32'h1);
            chk($sformatf("%s_grant%0d_is_ls", nf ? "nf" : "fair", g), {31'h0, win_ls}, {31'h0, exp_ls[g]});
            if (nf) begin
                if (win_ls) nf_ls_req = 1'b0; else nf_if_req = 1'b0;
            end else begin
                if (win_ls) ls_req = 1'b0; else if_req = 1'b0;
            end
            @(negedge clk);
            if (g < 3) begin
                if (nf) begin
                    if (win_ls) nf_ls_req = 1'b1; else nf_if_req = 1'b1;
                end else begin
                    if (win_ls) ls_req = 1'b1; else if_req = 1'b1;
                end
            end
        end
        drop_reqs();
        ram_ready = 1'b0;
    endtask

    initial begin
        logic        acks;
        int          cs_n;
        int          lat;
        bit          got;
        logic [31:0] rd;
        logic        er;

        //           ls st addr          sz     sg wdata         rdata         dly be     maddr         wdata         rdata         err
        vecs[0]  = '{0, 0, 32'h0000_0100, 2'b10, 0, 32'h0,        32'hE3A0_1005, 0, 4'hF, 32'h0000_0100, 32'h0,        32'hE3A0_1005, 0};
        vecs[1]  = '{1, 0, 32'h0000_0203, 2'b00, 1, 32'h0,        32'h80FF_FFFF, 0, 4'h8, 32'h0000_0200, 32'h0,        32'hFFFF_FF80, 0};
        vecs[2]  = '{1, 0, 32'h0000_0203, 2'b00, 0, 32'h0,        32'h80FF_FFFF, 0, 4'h8, 32'h0000_0200, 32'h0,        32'h0000_0080, 0};
        vecs[3]  = '{1, 1, 32'h0000_0302, 2'b01, 0, 32'h0000_BEEF, 32'h0,        0, 4'hC, 32'h0000_0300, 32'hBEEF_BEEF, 32'h0,        0};
        vecs[4]  = '{1, 1, 32'h0000_0001, 2'b00, 0, 32'h0000_00A5, 32'h0,        0, 4'h2, 32'h0000_0000, 32'hA5A5_A5A5, 32'h0,        0};
        vecs[5]  = '{1, 0, 32'h0000_0102, 2'b01, 1, 32'h0,        32'h8001_7FFF, 0, 4'hC, 32'h0000_0100, 32'h0,        32'hFFFF_8001, 0};
        vecs[6]  = '{1, 0, 32'h0000_0100, 2'b01, 0, 32'h0,        32'h1234_F00D, 0, 4'h3, 32'h0000_0100, 32'h0,        32'h0000_F00D, 0};
        vecs[7]  = '{1, 1, 32'h0000_040C, 2'b10, 0, 32'hDEAD_BEEF, 32'h0,        0, 4'hF, 32'h0000_040C, 32'hDEAD_BEEF, 32'h0,        0};
        vecs[8]  = '{1, 0, 32'h0000_0208, 2'b10, 0, 32'h0,        32'h89AB_CDEF, 3, 4'hF, 32'h0000_0208, 32'h0,        32'h89AB_CDEF, 0};
        vecs[9]  = '{1, 0, 32'h0000_0401, 2'b10, 0, 32'h0,        32'h0,        0, 4'h0, 32'h0,        32'h0,        32'h0,        1};
        vecs[10] = '{1, 0, 32'h0000_0103, 2'b01, 1, 32'h0,        32'h0,        0, 4'h0, 32'h0,        32'h0,        32'h0,        1};
        vecs[11] = '{1, 0, 32'h0000_0400, 2'b11, 0, 32'h0,        32'h0,        0, 4'h0, 32'h0,        32'h0,        32'h0,        1};
        vecs[12] = '{0, 0, 32'h0000_07FC, 2'b10, 0, 32'h0,        32'h0BAD_F00D, 1, 4'hF, 32'h0000_07FC, 32'h0,        32'h0BAD_F00D, 0};
        vecs[13] = '{1, 0, 32'h0000_0201, 2'b00, 1, 32'h0,        32'h0000_7F00, 0, 4'h2, 32'h0000_0200, 32'h0,        32'h0000_007F, 0};

        rst = 1'b1;
        drop_reqs();
        if_addr = 32'h0; ls_we = 1'b0; ls_addr = 32'h0; ls_size = 2'b00; ls_signed = 1'b0;
        ls_wdata = 32'h0; mem_rdata = 32'h0; ram_ready = 1'b0;

        // Reset state.
        @(negedge clk);
        chk("reset_ctrl", {24'h0, cs, we, oe, busy, if_ack, ls_ack, if_err, ls_err}, 32'h0);
        chk("reset_mem_addr", mem_addr, 32'h0);
        chk("reset_mem_be_wdata", mem_wdata | {28'h0, mem_be}, 32'h0);
        chk("reset_rdata", if_rdata | ls_rdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Table of single accesses.
        for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

        // Fetch data held outside ack after later LS accesses.
        chk("if_rdata_hold", if_rdata, 32'h0BAD_F00D);
        chk("ls_rdata_hold", ls_rdata, 32'h0000_007F);

        // Contention: fair alternates starting with LS; non-fair LS always wins.
        do_reset();
        contend(1'b0, 5'b10101);
        do_reset();
        contend(1'b1, 5'b01111);

        // Reset during ACCESS: strobes drop at once, no ack follows.
        do_reset();
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_0500; ls_size = 2'b10; ls_signed = 1'b0;
        ram_ready = 1'b0;
        @(negedge clk);
        chk("rst_mid_cs_before", {31'h0, cs}, 32'h1);
        #2;
        rst = 1'b1;
        ls_req = 1'b0;
        #1;
        chk("rst_mid_cs_after", {29'h0, cs, oe, busy}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        acks = 1'b0;
        repeat (5) begin
            @(negedge clk);
            acks = acks | if_ack | ls_ack | cs;
        end
        chk("rst_mid_no_ack", {31'h0, acks}, 32'h0);

`ifdef MEM_TIMEOUT_EN
        // Timeout: ram_ready never comes; ack after 8 ACCESS cycles with err.
        run_vec(100, vecs[1]);
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_0600; ls_size = 2'b10; ls_signed = 1'b0;
        mem_rdata = 32'h5555_AAAA;
        ram_ready = 1'b0;
        cs_n = 0; lat = 0; got = 1'b0; rd = 32'hFFFF_FFFF; er = 1'b0;
        for (int k = 1; k <= 40 && !got; k++) begin
            @(negedge clk);
            if (cs) cs_n++;
            if (ls_ack) begin
                got = 1'b1; lat = k; rd = ls_rdata; er = ls_err;
            end
        end
        ls_req = 1'b0;
        chk("tmo_acked", {31'h0, got}, 32'h1);
        chk("tmo_cs_cycles", cs_n, 32'd8);
        chk("tmo_latency", lat, 32'd9);
        chk("tmo_err", {31'h0, er}, 32'h1);
        chk("tmo_rdata", rd, 32'h0);
        @(negedge clk);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
